// File: rtl/l2_set_buf_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// l2_set_buf_ctrl_pkg
// Shared definitions for the L2 set-buffer controller: default geometry of
// the L2 (ways, set/tag/state widths), the encoding of the invalid state,
// the set-buffer FSM encoding and convenience typedefs for tags, states,
// set indices and way indices.
// -----------------------------------------------------------------------------
package l2_set_buf_ctrl_pkg;

   localparam int L2_WAYS           = 4;
   localparam int L2_SET_BITS       = 8;
   localparam int L2_TAG_BITS       = 16;
   localparam int STABLE_STATE_BITS = 2;

   // Per-way state value meaning "no line held".
   localparam logic [STABLE_STATE_BITS-1:0] INVALID = 2'd0;

   typedef logic [L2_TAG_BITS-1:0]       l2_tag_t;
   typedef logic [STABLE_STATE_BITS-1:0] state_t;
   typedef logic [L2_SET_BITS-1:0]       l2_set_t;
   typedef logic [$clog2(L2_WAYS)-1:0]   l2_way_t;

   // Set-buffer FSM: no set held / RAM read in flight / buffers hold a set.
   typedef enum logic [1:0] {
      SB_IDLE  = 2'd0,
      SB_READ  = 2'd1,
      SB_VALID = 2'd2
   } sb_state_e;

endpackage : l2_set_buf_ctrl_pkg

// File: rtl/l2_set_buf_ctrl_chk.sv
// -----------------------------------------------------------------------------
// l2_set_buf_ctrl_chk
// Simulation-only protocol checks for l2_set_buf_ctrl.
//   clk, rst           : clock and asynchronous active-low reset
//   i_upd_valid        : update request from the L2 FSM
//   i_in_valid_state   : controller FSM is in VALID
//   i_ram_rd_en        : RAM read strobe
//   i_ram_wr_en        : RAM write strobe
//   i_lookup_start     : lookup-start pulse
//   i_buf_valid        : buffers hold a complete set
// -----------------------------------------------------------------------------
module l2_set_buf_ctrl_chk (
   input  logic clk,
   input  logic rst,
   input  logic i_upd_valid,
   input  logic i_in_valid_state,
   input  logic i_ram_rd_en,
   input  logic i_ram_wr_en,
   input  logic i_lookup_start,
   input  logic i_buf_valid
);

   // Updates are only meaningful against a fully loaded set.
   a_upd_only_in_valid : assert property (@(posedge clk) disable iff (!rst)
      i_upd_valid |-> i_in_valid_state);

   // The shared RAM address cannot serve a read and a write together.
   a_no_rd_wr_overlap : assert property (@(posedge clk) disable iff (!rst)
      !(i_ram_rd_en && i_ram_wr_en));

   // The lookup stage is only started on a valid buffer.
   a_lookup_has_valid : assert property (@(posedge clk) disable iff (!rst)
      i_lookup_start |-> i_buf_valid);

endmodule : l2_set_buf_ctrl_chk

// File: rtl/l2_set_buf_ctrl_evict_ptr.sv
// -----------------------------------------------------------------------------
// l2_evict_ptr
// Write-enable generation for a per-way update of the buffered set.
//   i_upd_fire   : an update is being applied this cycle
//   i_evict_adv  : the update also advances the eviction pointer
//   i_upd_way    : way being updated
//   i_cur_ptr    : current (buffered) eviction pointer
//   o_way_mask   : one-hot way write enable, zero when no update
//   o_evict_en   : write enable for the eviction pointer
//   o_evict_ptr  : advanced eviction pointer (cur + 1, wraps WAYS-1 -> 0)
// -----------------------------------------------------------------------------
module l2_evict_ptr
   import l2_set_buf_ctrl_pkg::*;
#(
   parameter int WAYS = L2_WAYS
) (
   input  logic                     i_upd_fire,
   input  logic                     i_evict_adv,
   input  logic [$clog2(WAYS)-1:0]  i_upd_way,
   input  logic [$clog2(WAYS)-1:0]  i_cur_ptr,
   output logic [WAYS-1:0]          o_way_mask,
   output logic                     o_evict_en,
   output logic [$clog2(WAYS)-1:0]  o_evict_ptr
);

   localparam int WB = $clog2(WAYS);

   // WAYS is a power of two, so a plain WB-bit increment wraps modulo WAYS.
   assign o_evict_ptr = i_cur_ptr + WB'(1);
   assign o_evict_en  = i_upd_fire && i_evict_adv;

   // One-hot decode of the updated way, gated by the update strobe.
   always_comb begin
      o_way_mask = {WAYS{1'b0}};
      if (i_upd_fire) begin
         o_way_mask[i_upd_way] = 1'b1;
      end else begin
         o_way_mask = {WAYS{1'b0}};
      end
   end

endmodule : l2_evict_ptr

// File: rtl/l2_set_buf_ctrl.sv
// -----------------------------------------------------------------------------
// l2_set_buf_ctrl
// Producer side of the L2 set buffers. Loads one set (tags, states, evict
// pointer) from the tag/state RAMs, holds it for the lookup stage and applies
// per-way updates to buffer and RAM together.
//   clk, rst            : clock, asynchronous active-low reset
//   i_rd_req_valid/o_rd_req_ready, i_rd_set : set load request handshake
//   i_inv_buf           : drop the buffered set (top priority, aborts a read)
//   i_upd_*             : per-way tag/state update and evict-pointer advance
//   o_ram_rd_en, o_ram_set, i_ram_*_rd : RAM read port (data RD_LAT later)
//   o_ram_wr_*          : RAM write port (same cycle as the update)
//   o_tags_buf, o_states_buf, o_evict_way_buf, o_buf_set, o_buf_valid
//                       : buffered set presented to the lookup stage
//   o_lookup_start      : one-cycle pulse on the first cycle of a new set
// -----------------------------------------------------------------------------
module l2_set_buf_ctrl
   import l2_set_buf_ctrl_pkg::*;
#(
   parameter int WAYS     = L2_WAYS,
   parameter int SET_BITS = L2_SET_BITS,
   parameter int TAG_BITS = L2_TAG_BITS,
   parameter int ST_BITS  = STABLE_STATE_BITS,
   parameter int RD_LAT   = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        i_rd_req_valid,
   output logic                        o_rd_req_ready,
   input  logic [SET_BITS-1:0]         i_rd_set,
   input  logic                        i_inv_buf,
   input  logic                        i_upd_valid,
   input  logic [$clog2(WAYS)-1:0]     i_upd_way,
   input  logic [TAG_BITS-1:0]         i_upd_tag,
   input  logic [ST_BITS-1:0]          i_upd_state,
   input  logic                        i_upd_evict_adv,
   output logic                        o_ram_rd_en,
   output logic [SET_BITS-1:0]         o_ram_set,
   input  logic [WAYS*TAG_BITS-1:0]    i_ram_tags_rd,
   input  logic [WAYS*ST_BITS-1:0]     i_ram_states_rd,
   input  logic [$clog2(WAYS)-1:0]     i_ram_evict_rd,
   output logic                        o_ram_wr_en,
   output logic [WAYS-1:0]             o_ram_wr_way_mask,
   output logic [TAG_BITS-1:0]         o_ram_wr_tag,
   output logic [ST_BITS-1:0]          o_ram_wr_state,
   output logic                        o_ram_wr_evict_en,
   output logic [$clog2(WAYS)-1:0]     o_ram_wr_evict,
   output logic [WAYS*TAG_BITS-1:0]    o_tags_buf,
   output logic [WAYS*ST_BITS-1:0]     o_states_buf,
   output logic [$clog2(WAYS)-1:0]     o_evict_way_buf,
   output logic [SET_BITS-1:0]         o_buf_set,
   output logic                        o_buf_valid,
   output logic                        o_lookup_start
);

   localparam int                 WB         = $clog2(WAYS);
   localparam logic [ST_BITS-1:0] ST_INVALID = ST_BITS'(INVALID);
   localparam logic [1:0]         LAT_LOAD   = 2'(RD_LAT);

   sb_state_e                  r_state;
   sb_state_e                  w_state_nxt;
   logic [1:0]                 r_cnt;
   logic [SET_BITS-1:0]        r_buf_set;
   logic                       r_buf_valid;
   logic                       r_lookup_start;
   logic [WAYS*TAG_BITS-1:0]   r_tags_buf;
   logic [WAYS*ST_BITS-1:0]    r_states_buf;
   logic [WB-1:0]              r_evict_way_buf;

   logic                       w_accept;
   logic                       w_upd_fire;
   logic                       w_capture;
   logic [WAYS-1:0]            w_way_mask;
   logic                       w_evict_en;
   logic [WB-1:0]              w_evict_nxt;

   // An update owns the RAM port this cycle, so it blocks a new request.
   assign o_rd_req_ready = (r_state != SB_READ) && !i_upd_valid && !i_inv_buf;
   assign w_accept       = i_rd_req_valid && o_rd_req_ready;
   assign w_upd_fire     = i_upd_valid && (r_state == SB_VALID) && !i_inv_buf;
   // RAM data is present on the cycle the down-counter steps from 1 to 0.
   assign w_capture      = (r_state == SB_READ) && (r_cnt == 2'd1) && !i_inv_buf;

   l2_evict_ptr #(
      .WAYS (WAYS)
   ) u_evict_ptr (
      .i_upd_fire  (w_upd_fire),
      .i_evict_adv (i_upd_evict_adv),
      .i_upd_way   (i_upd_way),
      .i_cur_ptr   (r_evict_way_buf),
      .o_way_mask  (w_way_mask),
      .o_evict_en  (w_evict_en),
      .o_evict_ptr (w_evict_nxt)
   );

   assign o_ram_rd_en       = w_accept;
   assign o_ram_wr_en       = w_upd_fire;
   assign o_ram_wr_way_mask = w_way_mask;
   assign o_ram_wr_tag      = i_upd_tag;
   assign o_ram_wr_state    = i_upd_state;
   assign o_ram_wr_evict_en = w_evict_en;
   assign o_ram_wr_evict    = w_evict_nxt;

   assign o_tags_buf        = r_tags_buf;
   assign o_states_buf      = r_states_buf;
   assign o_evict_way_buf   = r_evict_way_buf;
   assign o_buf_set         = r_buf_set;
   assign o_buf_valid       = r_buf_valid;
   assign o_lookup_start    = r_lookup_start;

   // RAM address: the requested set on the accept cycle, otherwise the held set.
   always_comb begin
      o_ram_set = r_buf_set;
      if (w_accept) begin
         o_ram_set = i_rd_set;
      end else begin
         o_ram_set = r_buf_set;
      end
   end

   // Next-state logic; invalidate overrides every other transition.
   always_comb begin
      w_state_nxt = r_state;
      if (i_inv_buf) begin
         w_state_nxt = SB_IDLE;
      end else begin
         case (r_state)
            SB_IDLE: begin
               if (w_accept) begin
                  w_state_nxt = SB_READ;
               end else begin
                  w_state_nxt = SB_IDLE;
               end
            end
            SB_READ: begin
               if (w_capture) begin
                  w_state_nxt = SB_VALID;
               end else begin
                  w_state_nxt = SB_READ;
               end
            end
            SB_VALID: begin
               if (w_accept) begin
                  w_state_nxt = SB_READ;
               end else begin
                  w_state_nxt = SB_VALID;
               end
            end
            default: begin
               w_state_nxt = SB_IDLE;
            end
         endcase
      end
   end

   // FSM state, read-latency counter, buffered set index and valid flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state        <= SB_IDLE;
         r_cnt          <= 2'd0;
         r_buf_set      <= {SET_BITS{1'b0}};
         r_buf_valid    <= 1'b0;
         r_lookup_start <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_lookup_start <= w_capture;
         if (i_inv_buf) begin
            r_cnt       <= 2'd0;
            r_buf_valid <= 1'b0;
         end else if (w_accept) begin
            r_cnt       <= LAT_LOAD;
            r_buf_set   <= i_rd_set;
            r_buf_valid <= 1'b0;
         end else if (w_capture) begin
            r_cnt       <= 2'd0;
            r_buf_valid <= 1'b1;
         end else if (r_cnt != 2'd0) begin
            r_cnt       <= r_cnt - 2'd1;
         end
      end
   end

   // Set contents: whole-set load from RAM, or a single-way update.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_tags_buf      <= {(WAYS*TAG_BITS){1'b0}};
         r_states_buf    <= {WAYS{ST_INVALID}};
         r_evict_way_buf <= {WB{1'b0}};
      end else if (w_capture) begin
         r_tags_buf      <= i_ram_tags_rd;
         r_states_buf    <= i_ram_states_rd;
         r_evict_way_buf <= i_ram_evict_rd;
      end else begin
         for (int w = 0; w < WAYS; w++) begin
            if (w_way_mask[w]) begin
               r_tags_buf[w*TAG_BITS +: TAG_BITS] <= i_upd_tag;
               r_states_buf[w*ST_BITS +: ST_BITS] <= i_upd_state;
            end
         end
         if (w_evict_en) begin
            r_evict_way_buf <= w_evict_nxt;
         end
      end
   end

   l2_set_buf_ctrl_chk u_chk (
      .clk              (clk),
      .rst              (rst),
      .i_upd_valid      (i_upd_valid),
      .i_in_valid_state (r_state == SB_VALID),
      .i_ram_rd_en      (o_ram_rd_en),
      .i_ram_wr_en      (o_ram_wr_en),
      .i_lookup_start   (r_lookup_start),
      .i_buf_valid      (r_buf_valid)
   );

endmodule : l2_set_buf_ctrl

// File: tb/tb_l2_set_buf_ctrl.sv
// -----------------------------------------------------------------------------
// tb_l2_set_buf_ctrl
// Self-checking bench: dut (RD_LAT=1) exercises load, update table, request/
// update collision and reset during a read; dut2 (RD_LAT=3) exercises the
// longer latency and an invalidate that aborts a read.
// -----------------------------------------------------------------------------
module tb_l2_set_buf_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        rd_req_valid, rd_req_valid2;
   logic [7:0]  rd_set;
   logic        inv_buf, inv_buf2;
   logic        upd_valid, upd_valid2;
   logic [1:0]  upd_way;
   logic [15:0] upd_tag;
   logic [1:0]  upd_state;
   logic        upd_evict_adv;
   logic [63:0] ram_tags_rd;
   logic [7:0]  ram_states_rd;
   logic [1:0]  ram_evict_rd;

   logic        rd_req_ready, ram_rd_en, ram_wr_en, ram_wr_evict_en, buf_valid, lookup_start;
   logic [7:0]  ram_set, buf_set;
   logic [3:0]  ram_wr_way_mask;
   logic [15:0] ram_wr_tag;
   logic [1:0]  ram_wr_state, ram_wr_evict, evict_way_buf;
   logic [63:0] tags_buf;
   logic [7:0]  states_buf;

   logic        rd_req_ready2, ram_rd_en2, ram_wr_en2, ram_wr_evict_en2, buf_valid2, lookup_start2;
   logic [7:0]  ram_set2, buf_set2;
   logic [3:0]  ram_wr_way_mask2;
   logic [15:0] ram_wr_tag2;
   logic [1:0]  ram_wr_state2, ram_wr_evict2, evict_way_buf2;
   logic [63:0] tags_buf2;
   logic [7:0]  states_buf2;

   always #5 clk = ~clk;

   l2_set_buf_ctrl #(.RD_LAT(1)) dut (
      .clk(clk), .rst(rst),
      .i_rd_req_valid(rd_req_valid), .o_rd_req_ready(rd_req_ready), .i_rd_set(rd_set),
      .i_inv_buf(inv_buf), .i_upd_valid(upd_valid), .i_upd_way(upd_way),
      .i_upd_tag(upd_tag), .i_upd_state(upd_state), .i_upd_evict_adv(upd_evict_adv),
      .o_ram_rd_en(ram_rd_en), .o_ram_set(ram_set),
      .i_ram_tags_rd(ram_tags_rd), .i_ram_states_rd(ram_states_rd), .i_ram_evict_rd(ram_evict_rd),
      .o_ram_wr_en(ram_wr_en), .o_ram_wr_way_mask(ram_wr_way_mask), .o_ram_wr_tag(ram_wr_tag),
      .o_ram_wr_state(ram_wr_state), .o_ram_wr_evict_en(ram_wr_evict_en), .o_ram_wr_evict(ram_wr_evict),
      .o_tags_buf(tags_buf), .o_states_buf(states_buf), .o_evict_way_buf(evict_way_buf),
      .o_buf_set(buf_set), .o_buf_valid(buf_valid), .o_lookup_start(lookup_start)
   );

   l2_set_buf_ctrl #(.RD_LAT(3)) dut2 (
      .clk(clk), .rst(rst),
      .i_rd_req_valid(rd_req_valid2), .o_rd_req_ready(rd_req_ready2), .i_rd_set(rd_set),
      .i_inv_buf(inv_buf2), .i_upd_valid(upd_valid2), .i_upd_way(upd_way),
      .i_upd_tag(upd_tag), .i_upd_state(upd_state), .i_upd_evict_adv(upd_evict_adv),
      .o_ram_rd_en(ram_rd_en2), .o_ram_set(ram_set2),
      .i_ram_tags_rd(ram_tags_rd), .i_ram_states_rd(ram_states_rd), .i_ram_evict_rd(ram_evict_rd),
      .o_ram_wr_en(ram_wr_en2), .o_ram_wr_way_mask(ram_wr_way_mask2), .o_ram_wr_tag(ram_wr_tag2),
      .o_ram_wr_state(ram_wr_state2), .o_ram_wr_evict_en(ram_wr_evict_en2), .o_ram_wr_evict(ram_wr_evict2),
      .o_tags_buf(tags_buf2), .o_states_buf(states_buf2), .o_evict_way_buf(evict_way_buf2),
      .o_buf_set(buf_set2), .o_buf_valid(buf_valid2), .o_lookup_start(lookup_start2)
   );

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [63:0] tags;
      logic [7:0]  states;
      logic [1:0]  evict;
   } buf_exp_t;
   buf_exp_t sb_q[$];

   typedef struct {
      logic [1:0]  way;
      logic [15:0] tag;
      logic [1:0]  st;
      logic        adv;
      logic [3:0]  exp_mask;
      logic [1:0]  exp_evict;
   } upd_vec_t;
   upd_vec_t vecs[4];

   // Reference model of the buffered set.
   logic [63:0] m_tags;
   logic [7:0]  m_states;
   logic [1:0]  m_evict;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_upd(input logic [1:0] w, input logic [15:0] t, input logic [1:0] s,
                            input logic adv);
      buf_exp_t e;
      m_tags[w*16 +: 16] = t;
      m_states[w*2 +: 2] = s;
      if (adv) m_evict = m_evict + 2'd1;
      e.tags = m_tags; e.states = m_states; e.evict = m_evict;
      sb_q.push_back(e);
   endtask

   task automatic sb_check(input string nm);
      buf_exp_t e;
      if (sb_q.size() == 0) begin
         checks++; failures++;
         $display("FAIL %s scoreboard empty actual=0 required=1", nm);
      end else begin
         e = sb_q.pop_front();
         chk({nm, "_tags"},   tags_buf,            e.tags);
         chk({nm, "_states"}, 64'(states_buf),     64'(e.states));
         chk({nm, "_evict"},  64'(evict_way_buf),  64'(e.evict));
         chk({nm, "_valid"},  64'(buf_valid),      64'd1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b0;
      rd_req_valid = 1'b0; rd_req_valid2 = 1'b0; rd_set = 8'h00;
      inv_buf = 1'b0; inv_buf2 = 1'b0; upd_valid = 1'b0; upd_valid2 = 1'b0;
      upd_way = 2'd0; upd_tag = 16'h0000; upd_state = 2'd0; upd_evict_adv = 1'b0;
      ram_tags_rd = 64'h0; ram_states_rd = 8'h00; ram_evict_rd = 2'd0;

      vecs[0] = '{2'd1, 16'h0055, 2'd2, 1'b0, 4'b0010, 2'd2};
      vecs[1] = '{2'd3, 16'h0077, 2'd1, 1'b1, 4'b1000, 2'd3};
      vecs[2] = '{2'd0, 16'h0011, 2'd0, 1'b1, 4'b0001, 2'd0};
      vecs[3] = '{2'd2, 16'h00AB, 2'd3, 1'b1, 4'b0100, 2'd1};

      // ---------------- reset state ----------------
      repeat (2) @(posedge clk);
      #1;
      chk("rst_buf_valid", 64'(buf_valid), 64'd0);
      chk("rst_lookup",    64'(lookup_start), 64'd0);
      chk("rst_rd_en",     64'(ram_rd_en), 64'd0);
      chk("rst_wr_en",     64'(ram_wr_en), 64'd0);
      chk("rst_tags",      tags_buf, 64'd0);
      chk("rst_states",    64'(states_buf), 64'd0);
      chk("rst_evict",     64'(evict_way_buf), 64'd0);
      chk("rst_buf_set",   64'(buf_set), 64'd0);
      rst = 1'b1;
      step();

      // ---------------- load set 0x12, RD_LAT=1 ----------------
      ram_tags_rd   = {16'h000D, 16'h000C, 16'h000B, 16'h000A};
      ram_states_rd = {2'd3, 2'd2, 2'd0, 2'd1};
      ram_evict_rd  = 2'd2;
      rd_set = 8'h12; rd_req_valid = 1'b1;
      #1;
      chk("ld_ready",   64'(rd_req_ready), 64'd1);
      chk("ld_rd_en",   64'(ram_rd_en), 64'd1);
      chk("ld_ram_set", 64'(ram_set), 64'h12);
      step();
      rd_req_valid = 1'b0;
      chk("ld_c1_valid",  64'(buf_valid), 64'd0);
      chk("ld_c1_lookup", 64'(lookup_start), 64'd0);
      chk("ld_c1_set",    64'(buf_set), 64'h12);
      step();
      chk("ld_c2_valid",  64'(buf_valid), 64'd1);
      chk("ld_c2_lookup", 64'(lookup_start), 64'd1);
      chk("ld_c2_tags",   tags_buf, 64'h000D_000C_000B_000A);
      chk("ld_c2_states", 64'(states_buf), 64'hE1);
      chk("ld_c2_evict",  64'(evict_way_buf), 64'd2);
      step();
      chk("ld_c3_lookup", 64'(lookup_start), 64'd0);
      chk("ld_c3_valid",  64'(buf_valid), 64'd1);
      m_tags = 64'h000D_000C_000B_000A; m_states = 8'hE1; m_evict = 2'd2;

      // ---------------- update vector table ----------------
      for (int i = 0; i < 4; i++) begin
         upd_valid = 1'b1; upd_way = vecs[i].way; upd_tag = vecs[i].tag;
         upd_state = vecs[i].st; upd_evict_adv = vecs[i].adv;
         #1;
         chk($sformatf("upd%0d_wr_en", i),   64'(ram_wr_en), 64'd1);
         chk($sformatf("upd%0d_rd_en", i),   64'(ram_rd_en), 64'd0);
         chk($sformatf("upd%0d_ready", i),   64'(rd_req_ready), 64'd0);
         chk($sformatf("upd%0d_set", i),     64'(ram_set), 64'h12);
         chk($sformatf("upd%0d_mask", i),    64'(ram_wr_way_mask), 64'(vecs[i].exp_mask));
         chk($sformatf("upd%0d_tag", i),     64'(ram_wr_tag), 64'(vecs[i].tag));
         chk($sformatf("upd%0d_state", i),   64'(ram_wr_state), 64'(vecs[i].st));
         chk($sformatf("upd%0d_ev_en", i),   64'(ram_wr_evict_en), 64'(vecs[i].adv));
         if (vecs[i].adv) chk($sformatf("upd%0d_ev", i), 64'(ram_wr_evict), 64'(vecs[i].exp_evict));
         model_upd(vecs[i].way, vecs[i].tag, vecs[i].st, vecs[i].adv);
         step();
         upd_valid = 1'b0; upd_evict_adv = 1'b0;
         sb_check($sformatf("upd%0d_buf", i));
      end

      // ---------------- request and update in the same cycle ----------------
      rd_req_valid = 1'b1; rd_set = 8'h34;
      upd_valid = 1'b1; upd_way = 2'd2; upd_tag = 16'h0099; upd_state = 2'd1;
      #1;
      chk("col_ready", 64'(rd_req_ready), 64'd0);
      chk("col_rd_en", 64'(ram_rd_en), 64'd0);
      chk("col_wr_en", 64'(ram_wr_en), 64'd1);
      chk("col_set",   64'(ram_set), 64'h12);
      model_upd(2'd2, 16'h0099, 2'd1, 1'b0);
      step();
      upd_valid = 1'b0;
      ram_tags_rd = 64'h0004_0003_0002_0001; ram_states_rd = 8'h1B; ram_evict_rd = 2'd1;
      #1;
      sb_check("col_buf");
      chk("col2_ready", 64'(rd_req_ready), 64'd1);
      chk("col2_rd_en", 64'(ram_rd_en), 64'd1);
      chk("col2_set",   64'(ram_set), 64'h34);
      step();
      rd_req_valid = 1'b0;
      chk("col3_valid", 64'(buf_valid), 64'd0);
      chk("col3_set",   64'(buf_set), 64'h34);
      step();
      chk("col4_valid",  64'(buf_valid), 64'd1);
      chk("col4_lookup", 64'(lookup_start), 64'd1);
      chk("col4_tags",   tags_buf, 64'h0004_0003_0002_0001);
      chk("col4_states", 64'(states_buf), 64'h1B);
      chk("col4_evict",  64'(evict_way_buf), 64'd1);

      // ---------------- reset during READ ----------------
      rd_req_valid = 1'b1; rd_set = 8'h56;
      step();
      rd_req_valid = 1'b0;
      ram_tags_rd = 64'hFFFF_EEEE_DDDD_CCCC; ram_states_rd = 8'h93; ram_evict_rd = 2'd3;
      #2;
      rst = 1'b0;
      #1;
      chk("rr_valid",  64'(buf_valid), 64'd0);
      chk("rr_lookup", 64'(lookup_start), 64'd0);
      chk("rr_set",    64'(buf_set), 64'd0);
      chk("rr_tags",   tags_buf, 64'd0);
      chk("rr_states", 64'(states_buf), 64'd0);
      chk("rr_rd_en",  64'(ram_rd_en), 64'd0);
      step();
      rst = 1'b1;
      step();
      step();
      chk("rr2_valid",  64'(buf_valid), 64'd0);
      chk("rr2_lookup", 64'(lookup_start), 64'd0);
      chk("rr2_tags",   tags_buf, 64'd0);
      chk("rr2_evict",  64'(evict_way_buf), 64'd0);

      // ---------------- RD_LAT=3 load ----------------
      ram_tags_rd = 64'h1111_2222_3333_4444; ram_states_rd = 8'h6C; ram_evict_rd = 2'd1;
      rd_req_valid2 = 1'b1; rd_set = 8'h21;
      #1;
      chk("l3_rd_en", 64'(ram_rd_en2), 64'd1);
      chk("l3_set",   64'(ram_set2), 64'h21);
      step();
      rd_req_valid2 = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         chk($sformatf("l3_c%0d_valid", c), 64'(buf_valid2), 64'd0);
         chk($sformatf("l3_c%0d_ready", c), 64'(rd_req_ready2), 64'd0);
         step();
      end
      chk("l3_c4_valid",  64'(buf_valid2), 64'd1);
      chk("l3_c4_lookup", 64'(lookup_start2), 64'd1);
      chk("l3_c4_tags",   tags_buf2, 64'h1111_2222_3333_4444);
      chk("l3_c4_states", 64'(states_buf2), 64'h6C);
      chk("l3_c4_set",    64'(buf_set2), 64'h21);
      step();
      chk("l3_c5_lookup", 64'(lookup_start2), 64'd0);

      // ---------------- RD_LAT=3 invalidate one cycle after accept ----------------
      rd_req_valid2 = 1'b1; rd_set = 8'h22;
      step();
      rd_req_valid2 = 1'b0; inv_buf2 = 1'b1;
      #1;
      chk("inv_ready", 64'(rd_req_ready2), 64'd0);
      step();
      inv_buf2 = 1'b0;
      for (int c = 0; c < 4; c++) begin
         chk($sformatf("inv_c%0d_valid", c),  64'(buf_valid2), 64'd0);
         chk($sformatf("inv_c%0d_lookup", c), 64'(lookup_start2), 64'd0);
         step();
      end
      chk("inv_idle_ready", 64'(rd_req_ready2), 64'd1);
      chk("inv_wr_en",      64'(ram_wr_en2), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_l2_set_buf_ctrl
